// File: rtl/noc_pkg.sv
// Shared NoC router definitions: direction codes, default sizing and arbiter FSM states.
package noc_pkg;

  localparam int unsigned N_PORT_DEF     = 5;
  localparam int unsigned N_REGISTER_DEF = 3;

  localparam logic [N_REGISTER_DEF-1:0] LOCAL = 3'd0;
  localparam logic [N_REGISTER_DEF-1:0] NORTH = 3'd1;
  localparam logic [N_REGISTER_DEF-1:0] EAST  = 3'd2;
  localparam logic [N_REGISTER_DEF-1:0] SOUTH = 3'd3;
  localparam logic [N_REGISTER_DEF-1:0] WEST  = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned N_PORT = 5,
  parameter int unsigned PTR_W  = 3
) (
  input  logic [N_PORT-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [N_PORT-1:0] gnt,
  output logic [PTR_W-1:0]  idx
);

  int unsigned j;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N_PORT; k++) begin
      j = (32'(ptr) + k) % N_PORT;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Per-output switch allocator: round-robin grant held for a whole packet, val/ret handshake toward the neighbour.
module output_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N_REGISTER = N_REGISTER_DEF,
  parameter int unsigned N_PORT     = N_PORT_DEF,
  parameter int unsigned PORT_ID    = 32'(LOCAL),
  parameter int unsigned PKT_LEN    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORT-1:0]            valid_in,
  input  logic [N_PORT*N_REGISTER-1:0] req_dir,
  input  logic [N_PORT*DATA_WIDTH-1:0] Data_in,
  output logic [N_PORT-1:0]            s_ack,
  output logic [N_PORT-1:0]            grant,
  output logic                         val,
  input  logic                         ret,
  output logic [DATA_WIDTH-1:0]        Data_out
);

  localparam int unsigned CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned PTR_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;

  arb_state_t        state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [N_PORT-1:0] grant_nxt;
  logic [PTR_W-1:0]  g_idx, g_idx_nxt;

  logic [N_PORT-1:0] req;
  logic [N_PORT-1:0] rr_gnt;
  logic [PTR_W-1:0]  rr_idx;
  logic              send;
  logic              xfer;

  for (genvar i = 0; i < N_PORT; i++) begin : g_req
    assign req[i] = valid_in[i] &&
                    (req_dir[i*N_REGISTER +: N_REGISTER] == N_REGISTER'(PORT_ID));
  end

  rr_arbiter #(
    .N_PORT (N_PORT),
    .PTR_W  (PTR_W)
  ) u_rr (
    .req (req),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // Output mux; grant is one-hot, so an OR-reduction selects the granted flit.
  always_comb begin
    send     = (state == SEND);
    val      = send && |(valid_in & grant);
    xfer     = val && ret;
    s_ack    = xfer ? grant : '0;
    Data_out = '0;
    for (int i = 0; i < N_PORT; i++) begin
      if (send && grant[i]) begin
        Data_out = Data_out | Data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    grant_nxt = grant;
    g_idx_nxt = g_idx;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt = rr_gnt;
          g_idx_nxt = rr_idx;
          cnt_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (cnt == CNT_W'(PKT_LEN - 1)) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            cnt_nxt   = '0;
            ptr_nxt   = (g_idx == PTR_W'(N_PORT - 1)) ? '0 : g_idx + 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      grant <= '0;
      g_idx <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      grant <= grant_nxt;
      g_idx <= g_idx_nxt;
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter serving EAST with 4-flit packets and 5 inputs.
module tb_output_arbiter;
  import noc_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 3;
  localparam int unsigned NP = 5;
  localparam int unsigned PL = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     valid_in;
  logic [NP*NR-1:0]  req_dir;
  logic [NP*DW-1:0]  Data_in;
  logic [NP-1:0]     s_ack;
  logic [NP-1:0]     grant;
  logic              val;
  logic              ret;
  logic [DW-1:0]     Data_out;

  logic [DW-1:0]     din [NP];
  logic [NR-1:0]     dir [NP];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_dir = '0;
    Data_in = '0;
    for (int i = 0; i < NP; i++) begin
      req_dir[i*NR +: NR] = dir[i];
      Data_in[i*DW +: DW] = din[i];
    end
  end

  output_arbiter #(
    .DATA_WIDTH (DW),
    .N_REGISTER (NR),
    .N_PORT     (NP),
    .PORT_ID    (32'(EAST)),
    .PKT_LEN    (PL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .req_dir  (req_dir),
    .Data_in  (Data_in),
    .s_ack    (s_ack),
    .grant    (grant),
    .val      (val),
    .ret      (ret),
    .Data_out (Data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    valid_in = '0;
    ret      = 1'b1;
    for (int i = 0; i < NP; i++) begin
      din[i] = '0;
      dir[i] = LOCAL;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic chk_send(input string tag, input int g, input logic [DW-1:0] d);
    check({tag, "_grant"}, 32'(grant), 32'(32'd1 << g));
    check({tag, "_val"},   32'(val), 32'd1);
    check({tag, "_sack"},  32'(s_ack), 32'(32'd1 << g));
    check({tag, "_data"},  32'(Data_out), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int order [4];
    order[0] = 0; order[1] = 3; order[2] = 4; order[3] = 0;
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    settle();

    // Reset state
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_val",   32'(val), 32'd0);
    check("rst_sack",  32'(s_ack), 32'd0);
    check("rst_data",  32'(Data_out), 32'd0);
    check("rst_ptr",   32'(dut.ptr), 32'd0);
    check("rst_cnt",   32'(dut.cnt), 32'd0);

    // Single packet from input 1
    dir[1] = EAST; valid_in = 5'b00010; din[1] = 8'hA0;
    settle();
    check("sp_idle_val",   32'(val), 32'd0);
    check("sp_idle_grant", 32'(grant), 32'd0);
    check("sp_idle_data",  32'(Data_out), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      din[1] = 8'(8'hA0 + k);
      settle();
      chk_send($sformatf("sp_f%0d", k), 1, 8'(8'hA0 + k));
      tick();
    end
    valid_in = '0;
    settle();
    check("sp_end_grant", 32'(grant), 32'd0);
    check("sp_end_val",   32'(val), 32'd0);
    check("sp_end_ptr",   32'(dut.ptr), 32'd2);

    // Round-robin among inputs 0, 3, 4
    do_reset();
    dir[0] = EAST; dir[3] = EAST; dir[4] = EAST;
    din[0] = 8'h05; din[3] = 8'h35; din[4] = 8'h45;
    valid_in = 5'b11001;
    settle();
    for (int p = 0; p < 4; p++) begin
      tick();
      chk_send($sformatf("rr_p%0d_first", p), order[p], din[order[p]]);
      tick(); tick(); tick();
      check($sformatf("rr_p%0d_last_sack", p), 32'(s_ack), 32'(32'd1 << order[p]));
      tick();
      check($sformatf("rr_p%0d_bubble", p), 32'(grant), 32'd0);
      check($sformatf("rr_p%0d_bubble_val", p), 32'(val), 32'd0);
    end

    // Backpressure mid-packet
    do_reset();
    dir[1] = EAST; din[1] = 8'h5A; valid_in = 5'b00010;
    settle();
    tick(); tick(); tick();
    ret = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("bp_s%0d_val", c),   32'(val), 32'd1);
      check($sformatf("bp_s%0d_sack", c),  32'(s_ack), 32'd0);
      check($sformatf("bp_s%0d_cnt", c),   32'(dut.cnt), 32'd2);
      check($sformatf("bp_s%0d_grant", c), 32'(grant), 32'b00010);
      tick();
    end
    ret = 1'b1;
    settle();
    check("bp_f3_sack", 32'(s_ack), 32'b00010);
    check("bp_f3_cnt",  32'(dut.cnt), 32'd2);
    tick();
    check("bp_f4_sack", 32'(s_ack), 32'b00010);
    check("bp_f4_cnt",  32'(dut.cnt), 32'd3);
    tick();
    check("bp_end_grant", 32'(grant), 32'd0);

    // Source stall with a competing requester on input 4
    do_reset();
    dir[1] = EAST; dir[4] = EAST; din[1] = 8'h11; din[4] = 8'h44;
    valid_in = 5'b10010;
    settle();
    tick(); tick(); tick();
    valid_in = 5'b10000;
    for (int c = 0; c < 2; c++) begin
      settle();
      check($sformatf("ss_s%0d_val", c),   32'(val), 32'd0);
      check($sformatf("ss_s%0d_sack", c),  32'(s_ack), 32'd0);
      check($sformatf("ss_s%0d_grant", c), 32'(grant), 32'b00010);
      tick();
    end
    valid_in = 5'b10010;
    settle();
    chk_send("ss_f3", 1, 8'h11);
    tick();
    chk_send("ss_f4", 1, 8'h11);
    tick();
    check("ss_idle_grant", 32'(grant), 32'd0);
    check("ss_idle_ptr",   32'(dut.ptr), 32'd2);
    tick();
    chk_send("ss_next", 4, 8'h44);

    // Filtering, then ptr=4 priority and wrap to 0
    do_reset();
    dir[4] = SOUTH; din[4] = 8'h4F; valid_in = 5'b10000;
    settle();
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("flt_c%0d_grant", c), 32'(grant), 32'd0);
      check($sformatf("flt_c%0d_val", c),   32'(val), 32'd0);
    end
    dir[3] = EAST; din[3] = 8'h33; valid_in = 5'b11000;
    settle();
    tick();
    chk_send("wr_p3", 3, 8'h33);
    tick(); tick(); tick(); tick();
    check("wr_ptr4", 32'(dut.ptr), 32'd4);
    dir[4] = EAST; dir[0] = EAST; din[0] = 8'h0C; valid_in = 5'b10001;
    settle();
    tick();
    chk_send("wr_p4", 4, 8'h4F);
    tick(); tick(); tick(); tick();
    check("wr_ptr0",  32'(dut.ptr), 32'd0);
    check("wr_idle",  32'(grant), 32'd0);
    tick();
    chk_send("wr_p0", 0, 8'h0C);

    // Asynchronous reset mid-packet
    do_reset();
    dir[1] = EAST; din[1] = 8'h77; valid_in = 5'b00010;
    settle();
    tick(); tick(); tick();
    check("mr_pre_sack", 32'(s_ack), 32'b00010);
    rst = 1'b1;
    settle();
    check("mr_grant", 32'(grant), 32'd0);
    check("mr_val",   32'(val), 32'd0);
    check("mr_sack",  32'(s_ack), 32'd0);
    check("mr_data",  32'(Data_out), 32'd0);
    check("mr_ptr",   32'(dut.ptr), 32'd0);
    check("mr_cnt",   32'(dut.cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk_send("mr_restart", 1, 8'h77);
    check("mr_restart_cnt", 32'(dut.cnt), 32'd0);
    tick(); tick(); tick();
    check("mr_last_cnt", 32'(dut.cnt), 32'd3);
    tick();
    check("mr_end_grant", 32'(grant), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
# output_arbiter

Per-output-port switch allocator for the NoC router. It collects route requests from all input blocks, grants the output port to one input per packet using round-robin, and drives the `val`/`ret` handshake and data to the neighbour router. It pops each forwarded flit from the granted input buffer by pulsing that input's `s_ack`. One instance sits on each router output (Local, N, E, S, W).

## Interface
Parameters:
- DATA_WIDTH, 8, flit width.
- N_REGISTER, 3, width of each input's direction code (`register`).
- N_PORT, 5, number of requesting input blocks.
- PORT_ID, 0, direction code served by this output. An input requests this port when its code equals PORT_ID.
- PKT_LEN, 4, flits per packet (≥1). The grant is held for exactly PKT_LEN transfers.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  N_PORT  input i has a flit at its buffer head (not empty).
- req_dir  in  N_PORT*N_REGISTER  direction code of input i, in slice [i*N_REGISTER +: N_REGISTER].
- Data_in  in  N_PORT*DATA_WIDTH  head flit of input i, in slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_ack  out  N_PORT  one-cycle pop pulse to the granted input on each transfer.
- grant  out  N_PORT  one-hot grant, registered. All zeros when idle.
- val  out  1  flit valid toward the neighbour.
- ret  in  1  neighbour can accept (high = buffer not full).
- Data_out  out  DATA_WIDTH  flit toward the neighbour.

## Operation
- Request: req[i] = valid_in[i] && (req_dir slice i == PORT_ID).
- FSM has two states, IDLE and SEND.
- IDLE:
  - If req is nonzero, pick the first set bit starting at ptr and wrapping N_PORT-1 → 0.
  - Register the choice as `grant`, clear cnt, and go to SEND.
  - If req is zero, stay in IDLE.
- SEND, with g = granted index:
  - val = valid_in[g]; Data_out = Data_in slice g.
  - A transfer occurs when val && ret. On a transfer, s_ack[g]=1 in the same cycle and cnt increments.
  - Transfer with cnt == PKT_LEN-1: go to IDLE, clear grant, ptr = (g+1) mod N_PORT.
- Lock: the grant is held across stalls. This covers `valid_in[g]` dropping mid-packet (val=0) and `ret` low (no s_ack). The arbiter never switches inputs mid-packet.
- Gating: outside SEND, val=0, s_ack=0 and Data_out=0.
- Requests from inputs whose code differs from PORT_ID are ignored. An input that withdraws before being granted is not considered.
- Width rules:
  - cnt width is max(1, clog2(PKT_LEN)).
  - ptr width is clog2(N_PORT); ptr wraps from N_PORT-1 to 0.
- Reset values: state=IDLE, ptr=0, cnt=0, grant=0, val=0, s_ack=0, Data_out=0.
- Reset mid-packet aborts the packet immediately. No further s_ack is issued.

## Timing
- Grant latency: req asserted in IDLE in cycle t → grant and val-eligible from cycle t+1.
- s_ack, val and Data_out are combinational from registered state plus `valid_in`/`ret`/`Data_in`. There is no added pipeline stage.
- Throughput: one flit per cycle while `ret` and `valid_in[g]` stay high.
- Between packets there is one IDLE bubble. Packets occupy PKT_LEN+1 cycles minimum.
- PKT_LEN=1: each flit is a packet and round-robin advances per flit.
- Simultaneous last-flit transfer and new requests: the new requests are evaluated in the following IDLE cycle using the updated ptr.

## Structure
- The shared package `noc_pkg` holds:
  - direction code constants: LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4 (N_REGISTER bits);
  - the N_PORT default.
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs are req[N_PORT] and ptr; outputs are a one-hot grant and its index.
- FSM, counter and output mux live in output_arbiter.

## Test plan
- Single packet: PORT_ID=2; input 1 valid with code 2, ret=1 → grant=00010 at t+1; val=1 for 4 cycles; s_ack[1] pulses 4 times; Data_out follows Data_in[1]; then IDLE and ptr=2.
- Round-robin: inputs 0, 3 and 4 request continuously with ptr=0 → grant order 0, 3, 4, 0, with one idle cycle between packets.
- Backpressure: ret=0 for 3 cycles mid-packet → val stays 1, s_ack=0, cnt frozen, grant unchanged; completes after ret returns.
- Source stall: valid_in[g] drops for 2 cycles after flit 2 → val=0; input 4 requesting is not granted until input g's 4th transfer.
- Filtering and wrap: input 4 requests with code ≠ PORT_ID → no grant. Input 4 with matching code and ptr=4 → grant 4, then ptr wraps to 0.
- Reset mid-packet: rst pulse after 2 transfers → val, s_ack and grant go to 0 immediately (asynchronously); ptr=0, cnt=0; the next request restarts at flit 0.
